// File: rtl/neuron_pkg.sv
// Shared types and defaults for the neuron front-end (feeder state encoding,
// default word format, neuron pass latency).
package neuron_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PRIME   = 2'd1,
    LOAD    = 2'd2,
    DELIVER = 2'd3
  } feeder_state_t;

  localparam int NEURON_DATA_WIDTH   = 8;
  localparam int NEURON_FRAC_BITS    = 4;
  // Cycles from Run rising (or from the previous Ready) to the next Ready pulse.
  localparam int NEURON_PASS_LATENCY = 7;

endpackage

// File: rtl/neuron_watchdog.sv
// Down-counting cycle watchdog: clear reloads, enable counts, expired flags the
// terminal count while enabled.
module neuron_watchdog #(
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else if (clear) begin
      cnt_q <= RELOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/neuron_input_feeder.sv
// Front end for one N_INPUTS-wide neuron: gathers input words, drives Run,
// skips the neuron's dummy first pass and offers Y downstream.
// Optional watchdog on PRIME/LOAD: define NEURON_FEEDER_TIMEOUT_EN.
//
// state   | meaning
// COLLECT | accept input words into x_vec slots 0..N_INPUTS-1
// PRIME   | Run high, waiting for the dummy (flush) Ready pulse
// LOAD    | Run high, waiting for the real Ready; Run drops in that cycle
// DELIVER | result held on m_data/m_valid until m_ready
module neuron_input_feeder
  import neuron_pkg::*;
#(
  parameter int DATA_WIDTH     = NEURON_DATA_WIDTH,
  parameter int FRAC_BITS      = NEURON_FRAC_BITS,
  parameter int N_INPUTS       = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [N_INPUTS*DATA_WIDTH-1:0] x_vec,
  output logic                           run,
  input  logic                           neuron_ready,
  input  logic [DATA_WIDTH-1:0]          neuron_y,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           m_err,
  output logic                           m_valid,
  input  logic                           m_ready
);
  localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);

  if (N_INPUTS < 1) begin : g_bad_n
    $error("N_INPUTS must be at least 1");
  end
  if ((FRAC_BITS < 0) || (FRAC_BITS >= DATA_WIDTH)) begin : g_bad_frac
    $error("FRAC_BITS must lie inside the data word");
  end
  if (TIMEOUT_CYCLES <= 2 * NEURON_PASS_LATENCY) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must exceed two neuron passes");
  end

  feeder_state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          in_hs;
  logic          last_word;
  logic          y_cap;
  logic          out_hs;
  logic          busy;
  logic          timeout_fire;

  assign in_hs     = s_valid && s_ready;
  assign last_word = in_hs && (cnt_q == LAST);
  assign y_cap     = (state_q == LOAD) && neuron_ready;
  assign out_hs    = m_valid && m_ready;
  assign busy      = (state_q == PRIME) || (state_q == LOAD);

`ifdef NEURON_FEEDER_TIMEOUT_EN
  logic wd_expired;

  neuron_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (last_word),
    .enable  (busy),
    .expired (wd_expired)
  );

  // A genuine Ready in the expiry cycle wins over the timeout.
  assign timeout_fire = wd_expired && !neuron_ready;
`else
  assign timeout_fire = 1'b0;
  assign m_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      COLLECT: begin
        if (last_word) state_d = PRIME;
      end
      PRIME: begin
        run = 1'b1;
        if (neuron_ready)      state_d = LOAD;
        else if (timeout_fire) state_d = DELIVER;
      end
      LOAD: begin
        run = !neuron_ready;
        if (neuron_ready || timeout_fire) state_d = DELIVER;
      end
      DELIVER: begin
        if (out_hs) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // s_ready is registered so it is low during and straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready <= 1'b0;
      cnt_q   <= '0;
      x_vec   <= '0;
    end else begin
      s_ready <= (state_d == COLLECT);
      if (in_hs) begin
        cnt_q <= last_word ? '0 : cnt_q + 1'b1;
        for (int i = 0; i < N_INPUTS; i++) begin
          if (cnt_q == CW'(i)) x_vec[i*DATA_WIDTH +: DATA_WIDTH] <= s_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
    end else if (y_cap) begin
      m_data  <= neuron_y;
      m_valid <= 1'b1;
    end else if (busy && timeout_fire) begin
      m_data  <= '0;
      m_valid <= 1'b1;
    end else if (out_hs) begin
      m_valid <= 1'b0;
    end
  end

`ifdef NEURON_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_err <= 1'b0;
    end else if (y_cap) begin
      m_err <= 1'b0;
    end else if (busy && timeout_fire) begin
      m_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_neuron_input_feeder.sv
// Directed bench for neuron_input_feeder with a behavioural 4-input neuron
// (weights 49,32,92,-78, hard-sigmoid style activation, 7-cycle passes).
module tb_neuron_input_feeder;
  localparam int DW = 8;
  localparam int NI = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     s_data;
  logic              s_valid;
  logic              s_ready;
  logic [NI*DW-1:0]  x_vec;
  logic              run;
  logic              neuron_ready;
  logic [DW-1:0]     neuron_y;
  logic [DW-1:0]     m_data;
  logic              m_err;
  logic              m_valid;
  logic              m_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_input_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .x_vec        (x_vec),
    .run          (run),
    .neuron_ready (neuron_ready),
    .neuron_y     (neuron_y),
    .m_data       (m_data),
    .m_err        (m_err),
    .m_valid      (m_valid),
    .m_ready      (m_ready)
  );

  // Behavioural neuron: counts Run-high cycles, pulses Ready at 7 and 14,
  // latches x_vec after the first (flush) pass which uses zeroed inputs.
  logic              stub_mute;
  logic              force_ready;
  logic [4:0]        nm_cnt;
  logic signed [7:0] nm_x [NI];
  int                w_tbl [NI] = '{49, 32, 92, -78};
  int                nm_acc;

  function automatic logic [DW-1:0] act(input int acc);
    if (acc >= 48)  return 8'd15;
    if (acc <= -48) return 8'd1;
    return 8'(8 + (acc >>> 3));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || !run) begin
      nm_cnt <= '0;
      for (int i = 0; i < NI; i++) nm_x[i] <= '0;
    end else begin
      if (nm_cnt != 5'd31) nm_cnt <= nm_cnt + 5'd1;
      if (nm_cnt == 5'd7) begin
        for (int i = 0; i < NI; i++) nm_x[i] <= x_vec[i*DW +: DW];
      end
    end
  end

  always_comb begin
    nm_acc = 0;
    for (int i = 0; i < NI; i++) nm_acc = nm_acc + int'(nm_x[i]) * w_tbl[i];
  end

  assign neuron_y     = act(nm_acc >>> 4);
  assign neuron_ready = (!stub_mute && ((nm_cnt == 5'd7) || (nm_cnt == 5'd14))) || force_ready;

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
    end
  endtask

  // Called and returning at a negedge; leaves s_valid low.
  task automatic feed_word(input logic [DW-1:0] d, input int gap);
    int n;
    repeat (gap) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("feed_wait", 64'(n < 100), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Starts at the negedge of the first PRIME cycle.
  task automatic finish_txn(input logic [NI*DW-1:0] exp_x, input logic [DW-1:0] exp_y,
                            input logic exp_err, input int exp_lat, input int mdelay);
    int cyc;
    int bad_x, bad_s, bad_run, bad_hold;
    cyc = 0; bad_x = 0; bad_s = 0; bad_run = 0; bad_hold = 0;
    while (!m_valid && cyc < 80) begin
      if (x_vec !== exp_x) bad_x++;
      if (s_ready !== 1'b0) bad_s++;
      if (run !== ((exp_lat == 15) ? (cyc != 14) : 1'b1)) bad_run++;
      @(negedge clk);
      cyc++;
    end
    check("result_latency", 64'(cyc), 64'(exp_lat));
    check("x_vec_stable", 64'(bad_x), 64'd0);
    check("s_ready_low_busy", 64'(bad_s), 64'd0);
    check("run_profile", 64'(bad_run), 64'd0);
    repeat (mdelay) begin
      if (m_valid !== 1'b1 || m_data !== exp_y || run !== 1'b0 || s_ready !== 1'b0) bad_hold++;
      @(negedge clk);
    end
    check("deliver_hold", 64'(bad_hold), 64'd0);
    check("m_data", 64'(m_data), 64'(exp_y));
    check("m_err", 64'(m_err), 64'(exp_err));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("m_valid_drop", 64'(m_valid), 64'd0);
    check("s_ready_back", 64'(s_ready), 64'd1);
  endtask

  typedef struct {
    logic [DW-1:0] x [NI];
    int            gap;
    int            mdelay;
    logic [DW-1:0] exp_y;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [NI*DW-1:0] pack(input vec_t v);
    return {v.x[3], v.x[2], v.x[1], v.x[0]};
  endfunction

  initial begin
    tbl[0] = '{x: '{8'd0,   8'd0,  8'd0, 8'd0},  gap: 0, mdelay: 0,  exp_y: 8'd8};
    tbl[1] = '{x: '{8'd16,  8'd0,  8'd0, 8'd0},  gap: 0, mdelay: 0,  exp_y: 8'd15};
    tbl[2] = '{x: '{8'd8,   8'd0,  8'd0, 8'd0},  gap: 2, mdelay: 10, exp_y: 8'd11};
    tbl[3] = '{x: '{8'd0,   8'd8,  8'd0, 8'd0},  gap: 0, mdelay: 3,  exp_y: 8'd10};
    tbl[4] = '{x: '{8'hF0,  8'd0,  8'd0, 8'd0},  gap: 0, mdelay: 1,  exp_y: 8'd1};
    tbl[5] = '{x: '{8'd0,   8'd0,  8'd0, 8'd16}, gap: 1, mdelay: 0,  exp_y: 8'd1};
    tbl[6] = '{x: '{8'd16,  8'd16, 8'd0, 8'd0},  gap: 0, mdelay: 0,  exp_y: 8'd15};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    force_ready = 1'b0; stub_mute = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_x_vec", 64'(x_vec), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_run", 64'(run), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_err", 64'(m_err), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < NI; i++) feed_word(tbl[t].x[i], tbl[t].gap);
      finish_txn(pack(tbl[t]), tbl[t].exp_y, 1'b0, 15, tbl[t].mdelay);
    end

    // Spurious Ready mid-collection must not disturb slot counter or state.
    feed_word(8'h04, 0);
    feed_word(8'hF8, 0);
    force_ready = 1'b1;
    @(negedge clk);
    check("spurious_run", 64'(run), 64'd0);
    force_ready = 1'b0;
    @(negedge clk);
    check("spurious_x_vec", 64'(x_vec), 64'h0000F804);
    check("spurious_s_ready", 64'(s_ready), 64'd1);
    feed_word(8'd0, 0);
    feed_word(8'd0, 0);
    finish_txn(32'h0000F804, 8'd7, 1'b0, 15, 0);

    // Reset while in LOAD, then a fresh stream.
    for (int i = 0; i < NI; i++) feed_word((i == 0) ? 8'd16 : 8'd0, 0);
    repeat (10) @(negedge clk);
    check("load_run", 64'(run), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_x_vec", 64'(x_vec), 64'd0);
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    check("midrst_run", 64'(run), 64'd0);
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_m_data", 64'(m_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) feed_word((i == 1) ? 8'd16 : 8'd0, 0);
    finish_txn(32'h00001000, 8'd12, 1'b0, 15, 2);

`ifdef NEURON_FEEDER_TIMEOUT_EN
    stub_mute = 1'b1;
    for (int i = 0; i < NI; i++) feed_word((i == 0) ? 8'd16 : 8'd0, 0);
    finish_txn(32'h00000010, 8'd0, 1'b1, 32, 2);
    stub_mute = 1'b0;
    for (int i = 0; i < NI; i++) feed_word((i == 0) ? 8'd16 : 8'd0, 0);
    finish_txn(32'h00000010, 8'd15, 1'b0, 15, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
